// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, constants and byte-enable helper for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int WORD_BYTES  = 4;
    localparam int MAX_LATENCY = 15;

    function automatic logic [8*WORD_BYTES-1:0] be_mask(input logic [WORD_BYTES-1:0] be);
        be_mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) be_mask[8*i +: 8] = {8{be[i]}};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-enable writes, registered read data and reset-clear
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    write,
    input  logic [AW-1:0]           addr,
    input  logic [31:0]             wdata,
    input  logic [WORD_BYTES-1:0]   be,
    output logic [31:0]             rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] mask;

    assign mask = be_mask(be);

    // Stores merge enabled bytes and return zero; loads register the word; clr zeroes the read data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (en) begin
            if (write) mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
            rdata <= write ? 32'h0 : mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with programmable wait states
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [WORD_BYTES-1:0]   req_be,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err
);

    localparam int CW = $clog2(MAX_LATENCY + 1);

    state_t                  state, state_next;
    logic [CW-1:0]           count;
    logic                    write_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [WORD_BYTES-1:0]   be_q;
    logic                    done;
    logic                    accept;
    logic                    access;
    logic                    err_now;

    // A response being consumed frees the slot in the same cycle, so back-to-back requests
    // are spaced LATENCY+1 cycles apart
    assign done       = state == RESP && resp_ready;
    assign req_ready  = !reset && (state == IDLE || done);
    assign accept     = req_valid && req_ready;
    assign access     = state == WAIT && count == '0;
    assign err_now    = addr_q[1:0] != 2'b00 || addr_q[31:2] >= 30'(DEPTH);
    assign resp_valid = state == RESP;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: accept -> WAIT, counter expiry -> RESP, consumed response -> IDLE
    always_comb begin
        state_next = state;
        state_next = accept ? WAIT : access ? RESP : done ? IDLE : state;
    end

    // Request capture and wait-state countdown
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            count   <= CW'(LATENCY - 1);
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end else if (state == WAIT && count != '0) begin
            count   <= count - 1'b1;
        end
    end

    // Error flag is decided at access time and held until the response is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       resp_err <= 1'b0;
        else if (access) resp_err <= err_now;
        else if (done)   resp_err <= 1'b0;
    end

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clock (clock),
        .reset (reset),
        .en    (access && !err_now),
        .clr   ((access && err_now) || done),
        .write (write_q),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (resp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        b_valid = 1'b0;
    logic        r1_ready, v1, e1, r15_ready, v15, e15;
    logic [31:0] d1, d15;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(256), .LATENCY(2), .AW(8)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1), .AW(8)) dut_l1 (
        .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(r1_ready),
        .req_write(1'b0), .req_addr(32'h0), .req_wdata(32'h0), .req_be(4'h0),
        .resp_valid(v1), .resp_ready(1'b1), .resp_rdata(d1), .resp_err(e1)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(15), .AW(8)) dut_l15 (
        .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(r15_ready),
        .req_write(1'b0), .req_addr(32'h0), .req_wdata(32'h0), .req_be(4'h0),
        .resp_valid(v15), .resp_ready(1'b1), .resp_rdata(d15), .resp_err(e15)
    );

    // One full transaction with resp_ready high; reports data, error and edges from accept to resp_valid
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clock); #1; lat++; end
        rd = resp_rdata; er = resp_err;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b want=0", resp_err); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL store_latency got=%0d want=2", lat); end
        vectors++; if (er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL store_resp got=%b/%h want=0/00000000", er, rd); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load_latency got=%0d want=2", lat); end
        vectors++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_basic got=%b/%h want=0/deadbeef", er, rd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        vectors++; if (rd !== 32'hDE22BE44) begin miscompares++; $display("FAIL be_0101 got=%h want=de22be44", rd); end
        xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL be_0000_err got=%b want=0", er); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        vectors++; if (rd !== 32'hDE22BE44) begin miscompares++; $display("FAIL be_0000_data got=%h want=de22be44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL misaligned_load got=%b/%h want=1/00000000", er, rd); end
        xact(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL range_store got=%b/%h want=1/00000000", er, rd); end
        xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        vectors++; if (er !== 1'b0 || rd !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL index0_kept got=%b/%h want=0/a5a5a5a5", er, rd); end
        xact(1'b1, 32'h13, 32'h0, 4'hF, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL misaligned_store got=%b want=1", er); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        vectors++; if (rd !== 32'hDE22BE44) begin miscompares++; $display("FAIL misaligned_no_write got=%h want=de22be44", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n;
        xact(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lat);
        @(negedge clock);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
        @(posedge clock); #1;
        req_addr = 32'h10;
        n = 0;
        while (!resp_valid && n < 50) begin @(posedge clock); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            vectors++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_%0d got=v%b/%h/rdy%b want=v1/cafef00d/rdy0", i, resp_valid, resp_rdata, req_ready);
            end
        end
        @(negedge clock);
        resp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL release_req_ready got=%b want=1", req_ready); end
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clock); #1; lat++; end
        vectors++; if (lat !== 2 || resp_rdata !== 32'hDE22BE44) begin miscompares++; $display("FAIL second_load got=%0d/%h want=2/de22be44", lat, resp_rdata); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd; logic er; int lat;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got=rdy%b v%b %h e%b want=rdy0 v0 00000000 e0", req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL no_stale_resp got=%b want=0", resp_valid); end
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        vectors++; if (er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL store_abandoned got=%b/%h want=0/00000000", er, rd); end
    endtask

    task automatic test_back_to_back();
        int f1 [2]; int f15 [2]; int n1; int n15;
        n1 = 0; n15 = 0;
        @(negedge clock);
        b_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (r1_ready) begin if (n1 < 2) f1[n1] = c; n1++; end
            if (r15_ready) begin if (n15 < 2) f15[n15] = c; n15++; end
            @(negedge clock);
        end
        b_valid = 1'b0;
        vectors++; if (n1 !== 40) begin miscompares++; $display("FAIL l1_accepts got=%0d want=40", n1); end
        vectors++; if (n15 !== 5) begin miscompares++; $display("FAIL l15_accepts got=%0d want=5", n15); end
        if (n1 >= 2) begin
            vectors++; if (f1[1] - f1[0] !== 2) begin miscompares++; $display("FAIL l1_period got=%0d want=2", f1[1] - f1[0]); end
        end
        if (n15 >= 2) begin
            vectors++; if (f15[1] - f15[0] !== 16) begin miscompares++; $display("FAIL l15_period got=%0d want=16", f15[1] - f15[0]); end
        end
        repeat (20) @(posedge clock);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_mid_store();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
